// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and the MEM stage.
// Serialises accesses through an IDLE/ACC/RESP FSM with last-served fairness.
module mem_arbiter #(
    parameter int WAIT_STATES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        freeze_if,
    output logic        freeze_pipe,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
    typedef enum logic {GNT_IF = 1'b0, GNT_DATA = 1'b1} grant_t;

    state_t     state;
    grant_t     grant;
    grant_t     last_grant;
    grant_t     next_grant;
    logic [3:0] cnt;
    logic       d_req;

    assign d_req = d_read | d_write;

    // Data wins a tie unless it was the last one served.
    always_comb begin
        next_grant = GNT_IF;
        if (d_req && if_req)
            next_grant = (last_grant == GNT_DATA) ? GNT_IF : GNT_DATA;
        else if (d_req)
            next_grant = GNT_DATA;
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= GNT_IF;
            last_grant <= GNT_IF;
            cnt        <= 4'd0;
            if_rdata   <= 32'd0;
            d_rdata    <= 32'd0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state  <= ACC;
                        grant  <= next_grant;
                        cnt    <= 4'(WAIT_STATES - 1);
                        mem_en <= 1'b1;
                        if (next_grant == GNT_DATA) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            // A simultaneous read and write is performed as a write.
                            mem_we    <= d_write;
                        end else begin
                            mem_addr <= if_addr;
                            mem_we   <= 1'b0;
                        end
                    end
                end
                ACC: begin
                    if (cnt == 4'd0) begin
                        state  <= RESP;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (grant == GNT_IF) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            if (!mem_we)
                                d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    last_grant <= grant;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign freeze_pipe = d_req & ~d_ready;
    assign freeze_if   = freeze_pipe | (if_req & ~if_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int WS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, d_ready, freeze_if, freeze_pipe, mem_en, mem_we;

    logic        u1_if_req = 1'b0;
    logic        u1_zero = 1'b0;
    logic [31:0] u1_if_addr = 32'h10, u1_zero32 = '0, u1_mem_rdata = 32'hCAFE_F00D;
    logic [31:0] u1_if_rdata, u1_d_rdata, u1_mem_addr, u1_mem_wdata;
    logic        u1_if_ready, u1_d_ready, u1_freeze_if, u1_freeze_pipe, u1_mem_en, u1_mem_we;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .freeze_if(freeze_if), .freeze_pipe(freeze_pipe),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.WAIT_STATES(1)) u1 (
        .clk(clk), .rst(rst),
        .if_req(u1_if_req), .if_addr(u1_if_addr), .if_rdata(u1_if_rdata), .if_ready(u1_if_ready),
        .d_read(u1_zero), .d_write(u1_zero), .d_addr(u1_zero32), .d_wdata(u1_zero32),
        .d_rdata(u1_d_rdata), .d_ready(u1_d_ready),
        .freeze_if(u1_freeze_if), .freeze_pipe(u1_freeze_pipe),
        .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr),
        .mem_wdata(u1_mem_wdata), .mem_rdata(u1_mem_rdata)
    );

    // Memory device: combinational read, write on clock edges while enabled.
    logic [31:0] dev_mem [16];
    assign mem_rdata = dev_mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_en && mem_we) dev_mem[mem_addr[5:2]] <= mem_wdata;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    int n_checks = 0, n_pass = 0;
    int t = 0, t_base = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @t=%0d: got %h expected %h", tag, t - t_base, got, exp);
    endtask

    // Reference model: one outstanding transaction with start cycle m_s.
    logic [31:0] ref_mem [16];
    bit          m_busy, m_gnt, m_we, m_last;
    int          m_s;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata, m_mem_addr, m_mem_wdata;

    task automatic model_reset();
        m_busy = 0; m_last = 0; m_gnt = 0; m_we = 0;
        m_if_rdata = '0; m_d_rdata = '0; m_mem_addr = '0; m_mem_wdata = '0;
    endtask

    task automatic compare_all();
        bit acc, resp, e_ir, e_dr, e_fp, e_fi;
        acc  = m_busy && t >= m_s && t < m_s + WS;
        resp = m_busy && t == m_s + WS;
        e_ir = resp && !m_gnt;
        e_dr = resp && m_gnt;
        e_fp = (d_read | d_write) & ~e_dr;
        e_fi = e_fp | (if_req & ~e_ir);
        check("mem_en", 32'(mem_en), 32'(acc));
        check("mem_we", 32'(mem_we), 32'(acc && m_we));
        check("mem_addr", mem_addr, m_mem_addr);
        check("mem_wdata", mem_wdata, m_mem_wdata);
        check("if_ready", 32'(if_ready), 32'(e_ir));
        check("d_ready", 32'(d_ready), 32'(e_dr));
        check("if_rdata", if_rdata, m_if_rdata);
        check("d_rdata", d_rdata, m_d_rdata);
        check("freeze_pipe", 32'(freeze_pipe), 32'(e_fp));
        check("freeze_if", 32'(freeze_if), 32'(e_fi));
    endtask

    // Apply the effect of the clock edge that ends cycle t.
    task automatic advance();
        bit dreq;
        dreq = d_read | d_write;
        if (m_busy) begin
            if (t == m_s + WS - 1) begin
                if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
                else if (m_gnt) m_d_rdata = ref_mem[m_addr[5:2]];
                else m_if_rdata = ref_mem[m_addr[5:2]];
            end
            if (t == m_s + WS) begin
                m_busy = 0;
                m_last = m_gnt;
            end
        end else if (dreq || if_req) begin
            if (dreq && if_req) m_gnt = !m_last;
            else m_gnt = dreq;
            m_busy = 1;
            m_s = t + 1;
            m_we = m_gnt && d_write;
            m_addr = m_gnt ? d_addr : if_addr;
            m_wdata = d_wdata;
            m_mem_addr = m_addr;
            if (m_gnt) m_mem_wdata = d_wdata;
        end
    endtask

    logic [31:0] obs_mem_en, obs_mem_we, obs_ir, obs_dr, obs_fp, obs_fi, obs_store;
    logic [31:0] obs1_mem_en, obs1_ready;

    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd, input logic u1r);
        int idx;
        @(negedge clk);
        if_req = ir; if_addr = ia; d_read = dr; d_write = dw; d_addr = da; d_wdata = dd;
        u1_if_req = u1r;
        #1;
        compare_all();
        idx = t - t_base;
        if (idx >= 0 && idx < 32) begin
            obs_mem_en[idx] = mem_en;   obs_mem_we[idx] = mem_we;
            obs_ir[idx] = if_ready;     obs_dr[idx] = d_ready;
            obs_fp[idx] = freeze_pipe;  obs_fi[idx] = freeze_if;
            obs_store[idx] = (mem_addr == 32'h100) && (mem_wdata == 32'hDEAD_BEEF);
            obs1_mem_en[idx] = u1_mem_en; obs1_ready[idx] = u1_if_ready;
        end
        advance();
        t++;
    endtask

    // Asserts reset immediately (possibly mid-access), checks, then releases so
    // that the next cycle() call is cycle 0.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (3) begin
            @(negedge clk); #1;
            compare_all();
        end
        @(posedge clk); #2;
        rst = 1'b1;
        t_base = t;
        obs_mem_en = '0; obs_mem_we = '0; obs_ir = '0; obs_dr = '0;
        obs_fp = '0; obs_fi = '0; obs_store = '0; obs1_mem_en = '0; obs1_ready = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            dev_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        dev_mem[4] = 32'hE3A0_0005;
        ref_mem[4] = 32'hE3A0_0005;

        // Fetch, alongside a single fetch on the one-wait-state instance.
        do_reset();
        for (int k = 0; k < 7; k++) cycle(k <= 4, 32'h10, 0, 0, 0, 0, k == 0);
        check("fetch_mem_en", obs_mem_en, 32'h0E);
        check("fetch_if_ready", obs_ir, 32'h10);
        check("fetch_freeze_if", obs_fi, 32'h0F);
        check("fetch_rdata", if_rdata, 32'hE3A0_0005);
        check("ws1_mem_en", obs1_mem_en, 32'h2);
        check("ws1_ready", obs1_ready, 32'h4);
        check("ws1_rdata", u1_if_rdata, 32'hCAFE_F00D);

        // Simultaneous fetch and load: data first after reset.
        do_reset();
        for (int k = 0; k < 11; k++) cycle(k <= 9, 32'h10, k <= 4, 0, 32'h24, 0, 0);
        check("simul_mem_en", obs_mem_en, 32'h1CE);
        check("simul_d_ready", obs_dr, 32'h10);
        check("simul_if_ready", obs_ir, 32'h200);
        check("simul_freeze_pipe", obs_fp, 32'h0F);
        check("simul_freeze_if", obs_fi, 32'h1FF);
        check("simul_d_rdata", d_rdata, init_word(9));

        // Store.
        do_reset();
        for (int k = 0; k < 7; k++) cycle(0, 0, 0, k <= 4, 32'h100, 32'hDEAD_BEEF, 0);
        check("store_mem_we", obs_mem_we, 32'h0E);
        check("store_d_ready", obs_dr, 32'h10);
        check("store_stable", obs_store & 32'h0E, 32'h0E);
        check("store_d_rdata", d_rdata, 32'h0);

        // Fairness with both requesters held high.
        do_reset();
        for (int k = 0; k < 22; k++) cycle(1, 32'h10, 1, 0, 32'h8, 0, 0);
        check("fair_d_ready", obs_dr, 32'h0000_4010);
        check("fair_if_ready", obs_ir, 32'h0008_0200);

        // Reset during the second ACC cycle of a fetch.
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1, 32'h10, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        check("rst_abort_mem_en", 32'(mem_en), 32'h0);
        do_reset();
        for (int k = 0; k < 7; k++) cycle(k <= 4, 32'h10, 0, 0, 0, 0, 0);
        check("rst_restart_mem_en", obs_mem_en, 32'h0E);
        check("rst_restart_if_ready", obs_ir, 32'h10);

        // Randomized traffic including withdrawals and mid-access input changes.
        do_reset();
        for (int k = 0; k < 1500; k++)
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, $urandom, $urandom, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 3, meaning memory cycles per access, legal range 1..15.
REQ-002 The block SHALL use one clock clk; reset rst is asynchronous and active-low.
REQ-003 The block SHALL have port clk, input, 1, the rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port if_req, input, 1, the instruction-fetch request.
REQ-006 The block SHALL have port if_addr, input, 32, the fetch address.
REQ-007 The block SHALL have port if_rdata, output, 32, the fetched instruction.
REQ-008 The block SHALL have port if_ready, output, 1, a one-cycle pulse meaning if_rdata is valid.
REQ-009 The block SHALL have ports d_read and d_write, input, 1 each, the MEM-stage data requests.
REQ-010 The block SHALL have ports d_addr and d_wdata, input, 32 each, the data address and store data.
REQ-011 The block SHALL have port d_rdata, output, 32, the load data.
REQ-012 The block SHALL have port d_ready, output, 1, a one-cycle pulse meaning the data access is complete.
REQ-013 The block SHALL have port freeze_if, output, 1, which freezes the IF stage and the IF2ID register.
REQ-014 The block SHALL have port freeze_pipe, output, 1, which freezes the IF2ID, ID2EXE, EXE2MEM and MEM2WB registers and the PC.
REQ-015 The block SHALL have ports mem_en and mem_we, output, 1 each, the shared single-port memory enable and write strobe.
REQ-016 The block SHALL have ports mem_addr and mem_wdata, output, 32 each, and port mem_rdata, input, 32.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACC and RESP.
REQ-018 In IDLE with any request pending, the block SHALL register a grant and enter ACC on the next edge.
REQ-019 Arbitration SHALL be by last-served register last_grant (reset value IF): when both requests are pending, data wins unless last_grant==DATA, in which case IF wins.
REQ-020 When one request is pending alone, it SHALL be granted regardless of last_grant.
REQ-021 In ACC, mem_en=1 and mem_addr/mem_wdata/mem_we SHALL be held stable for exactly WAIT_STATES cycles, timed by a 4-bit down-counter loaded with WAIT_STATES-1.
REQ-022 On the last ACC cycle (counter==0), mem_rdata SHALL be captured into if_rdata or d_rdata according to the grant.
REQ-023 RESP SHALL last one cycle, assert the granted ready pulse, update last_grant, and return to IDLE.
REQ-024 Latency: a request sampled in IDLE at cycle t SHALL produce a ready pulse at cycle t+WAIT_STATES+1; throughput is one access per WAIT_STATES+2 cycles.
REQ-025 A write SHALL drive mem_we=1 in all ACC cycles and leave d_rdata unchanged.
REQ-026 If d_read and d_write are both high, the access SHALL be performed as a write.
REQ-027 If a request is withdrawn mid-access (e.g. a branch flush drops if_req), the access SHALL still complete and ready SHALL still pulse.
REQ-028 In IDLE and RESP, mem_en and mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their last value.
REQ-029 freeze_pipe SHALL equal (d_read|d_write) & ~d_ready (combinational).
REQ-030 freeze_if SHALL equal freeze_pipe | (if_req & ~if_ready) (combinational).
REQ-031 Input changes during ACC SHALL NOT affect the access in flight.

Reset
REQ-032 While rst=0, the FSM SHALL be forced to IDLE, last_grant to IF, and the counter to 0.
REQ-033 While rst=0, if_rdata, d_rdata, mem_addr and mem_wdata SHALL be 0, and if_ready, d_ready, mem_en and mem_we SHALL be 0.
REQ-034 Reset assertion mid-ACC SHALL abort the access immediately, with no ready pulse.
REQ-035 After reset release, arbitration SHALL restart from IDLE.

Verification (WAIT_STATES=3 unless stated; cycle 0 = first edge after reset release)
REQ-036 Fetch: if_req=1, if_addr=0x10, mem_rdata=0xE3A00005 -> mem_en=1 in cycles 1-3, if_ready=1 in cycle 4 with if_rdata=0xE3A00005, freeze_if=1 in cycles 0-3.
REQ-037 Simultaneous: if_req=1 and d_read=1 at cycle 0 -> data in ACC cycles 1-3 with d_ready at cycle 4; fetch in ACC cycles 6-8 with if_ready at cycle 9; freeze_pipe=1 in cycles 0-3.
REQ-038 Store: d_write=1, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we=1 and mem_addr/mem_wdata stable in cycles 1-3, d_ready at cycle 4, d_rdata stays 0.
REQ-039 Fairness: d_read and if_req held high continuously -> grants alternate DATA, IF, DATA, and neither ready gap exceeds 10 cycles.
REQ-040 Reset mid-operation: rst=0 during the second ACC cycle -> mem_en=0 immediately, no ready pulse; after release a new access starts with a full 3-cycle ACC.
REQ-041 WAIT_STATES=1: a single request -> mem_en=1 in cycle 1 only, ready at cycle 2.
